div_unit: RTL and testbench

- Iterative radix-2 integer divider in the EX stage, alongside the single-cycle ALU.
- Executes RV32M DIV, DIVU, REM and REMU over multiple cycles.
- Holds the pipeline through a stall output while it works.
- Presents a one-cycle result strobe that the EX/MEM register captures in place of the ALU result.

---
 rtl/div_unit.sv | 164 ++++++++++++++++
 tb/tb_div_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline while it works and emits a one-cycle result strobe.
module div_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      divop,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_next;

  logic [CNTW-1:0]   r_cnt;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dsr;
  logic              r_is_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_signed;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [XLEN-1:0]   w_fast_quo;
  logic [XLEN-1:0]   w_fast_rem;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_trial;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_step;
  logic [XLEN-1:0]   w_quo_step;
  logic [XLEN-1:0]   w_norm_res;

  // Operand decode and fast-path detection for the IDLE start cycle
  always_comb begin
    w_accept   = (r_state == IDLE) & start & ~flush;
    w_signed   = ~divop[0];
    w_div0     = (op2 == '0);
    w_ovf      = w_signed & (op1 == MIN_NEG) & (op2 == '1);
    w_fast     = w_div0 | w_ovf;
    w_abs1     = (w_signed & op1[XLEN-1]) ? -op1 : op1;
    w_abs2     = (w_signed & op2[XLEN-1]) ? -op2 : op2;
    // Fast-path results use the raw dividend, so no sign fix-up is applied
    w_fast_quo = w_div0 ? '1 : MIN_NEG;
    w_fast_rem = w_div0 ? op1 : '0;
    w_fast_res = divop[1] ? w_fast_rem : w_fast_quo;
  end

  // One restoring step; the final step also feeds the signed result fix-up
  always_comb begin
    w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    w_trial    = w_rem_sh - {1'b0, r_dsr};
    w_ge       = ~w_trial[XLEN];
    w_rem_step = w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    w_quo_step = {r_quo[XLEN-2:0], w_ge};
    if (r_is_rem) begin
      w_norm_res = r_neg_r ? -w_rem_step : w_rem_step;
    end else begin
      w_norm_res = r_neg_q ? -w_quo_step : w_quo_step;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and stall/strobe outputs; flush overrides everything
  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          stall  = 1'b1;
          w_next = w_fast ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (r_cnt == '0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (flush) begin
      w_next       = IDLE;
      stall        = 1'b0;
      result_valid = 1'b0;
    end
  end

  // Datapath registers: operand capture, iteration, result load on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dsr    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_is_rem <= divop[1];
      r_dsr    <= w_abs2;
      r_cnt    <= CNTW'(XLEN - 1);
      if (w_fast) begin
        r_quo    <= w_fast_quo;
        r_rem    <= w_fast_rem;
        r_neg_q  <= 1'b0;
        r_neg_r  <= 1'b0;
        r_result <= w_fast_res;
      end else begin
        r_quo    <= w_abs1;
        r_rem    <= '0;
        r_neg_q  <= w_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
        r_neg_r  <= w_signed & op1[XLEN-1];
      end
    end else if ((r_state == CALC) && !flush) begin
      r_quo <= w_quo_step;
      r_rem <= w_rem_step;
      r_cnt <= r_cnt - CNTW'(1);
      if (r_cnt == '0) begin
        r_result <= w_norm_res;
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with a plain-arithmetic reference.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  divop;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] last_res;

  div_unit #(.XLEN(32), .CNTW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .divop        (divop),
    .op1          (op1),
    .op2          (op2),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      chk("strobe stall", 32'(stall), 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected strobe", 32'(result_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk(e.nm, result, e.val);
      end
    end
  end

  // Issue one divide at posedge+1 and hold start until the strobe
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
    exp_t e;
    int   lat;
    int   stalls;
    int   seen_at;
    e.val    = ref_model(op, a, b);
    e.nm     = nm;
    last_res = e.val;
    sbq.push_back(e);
    lat      = is_fast(op, a, b) ? 1 : 33;
    divop    = op;
    op1      = a;
    op2      = b;
    start    = 1'b1;
    stalls   = 0;
    seen_at  = -1;
    for (int k = 0; k < 100 && seen_at < 0; k++) begin
      @(negedge clk);
      if (result_valid) seen_at = k;
      else if (stall) stalls++;
    end
    if (seen_at < 0) begin
      chk({nm, " timeout"}, 32'(result_valid), 32'd1);
    end else begin
      chk({nm, " latency"}, seen_at, lat);
    end
    chk({nm, " stalls"}, stalls, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    divop = 2'b00;
    op1   = '0;
    op2   = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset valid", 32'(result_valid), 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_div(2'b01, 32'd100, 32'd7, "DIVU 100/7");
    do_div(2'b11, 32'd100, 32'd7, "REMU 100/7");
    do_div(2'b00, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
    do_div(2'b10, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
    do_div(2'b00, 32'd7, 32'hFFFF_FFFE, "DIV 7/-2");
    do_div(2'b10, 32'd7, 32'hFFFF_FFFE, "REM 7/-2");
    do_div(2'b00, 32'd5, 32'd0, "DIV 5/0");
    do_div(2'b10, 32'd5, 32'd0, "REM 5/0");
    do_div(2'b01, 32'hFFFF_FFFF, 32'd0, "DIVU max/0");
    do_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
    do_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
    do_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "DIVU min/max");
    do_div(2'b10, 32'hFFFF_FFFB, 32'd0, "REM -5/0");

    // Flush in CALC cycle 10: no strobe, result keeps its last value
    divop = 2'b01; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush stall", 32'(stall), 32'd0);
    chk("flush valid", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post-flush stall", 32'(stall), 32'd0);
    chk("post-flush result", result, last_res);
    @(posedge clk);
    #1;
    do_div(2'b01, 32'd9, 32'd3, "DIVU 9/3 after flush");

    // Flush alongside start in IDLE: nothing accepted
    start = 1'b1; flush = 1'b1; divop = 2'b00; op1 = 32'd50; op2 = 32'd5;
    @(negedge clk);
    chk("idle flush stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle flush result", result, last_res);
    @(posedge clk);
    #1;

    // Back-to-back, then reset mid-operation
    do_div(2'b01, 32'hFFFF_FFFF, 32'd1, "B2B DIVU");
    do_div(2'b10, 32'h8000_0001, 32'd2, "B2B REM");
    divop = 2'b01; op1 = 32'd12345; op2 = 32'd17; start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midop reset stall", 32'(stall), 32'd0);
    chk("midop reset valid", 32'(result_valid), 32'd0);
    chk("midop reset result", result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = 32'($urandom_range(1, 20));
        4:       rb = -32'($urandom_range(1, 20));
        5:       begin ra = 32'($urandom_range(0, 1000)); rb = $urandom; end
        default: rb = $urandom;
      endcase
      do_div(rop, ra, rb, $sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
